// File: rtl/alu_issue_queue_if.sv
// alu_issue_queue_if
//   Bundles the two decode enqueue lanes, the execute-side stall and the
//   two registered issue slots of alu_issue_queue.
//   master : producer/consumer side (decode + execute)
//   slave  : the issue queue itself
//   Enqueue : enq{0,1}_valid/opr/is_br/rd/rs1/rs2/op1/op2, enq_ready
//   Issue   : issue_stall, a_valid/opr/is_br/rd/op1/op2, b_valid/opr/rd/op1/op2
interface alu_issue_queue_if;
  logic        enq0_valid;
  logic        enq1_valid;
  logic [3:0]  enq0_opr;
  logic [3:0]  enq1_opr;
  logic        enq0_is_br;
  logic        enq1_is_br;
  logic [4:0]  enq0_rd;
  logic [4:0]  enq0_rs1;
  logic [4:0]  enq0_rs2;
  logic [4:0]  enq1_rd;
  logic [4:0]  enq1_rs1;
  logic [4:0]  enq1_rs2;
  logic [63:0] enq0_op1;
  logic [63:0] enq0_op2;
  logic [63:0] enq1_op1;
  logic [63:0] enq1_op2;
  logic        enq_ready;
  logic        issue_stall;
  logic        a_valid;
  logic [3:0]  a_opr;
  logic        a_is_br;
  logic [4:0]  a_rd;
  logic [63:0] a_op1;
  logic [63:0] a_op2;
  logic        b_valid;
  logic [3:0]  b_opr;
  logic [4:0]  b_rd;
  logic [63:0] b_op1;
  logic [63:0] b_op2;

  modport master (
    output enq0_valid, enq1_valid, enq0_opr, enq1_opr, enq0_is_br, enq1_is_br,
           enq0_rd, enq0_rs1, enq0_rs2, enq1_rd, enq1_rs1, enq1_rs2,
           enq0_op1, enq0_op2, enq1_op1, enq1_op2, issue_stall,
    input  enq_ready, a_valid, a_opr, a_is_br, a_rd, a_op1, a_op2,
           b_valid, b_opr, b_rd, b_op1, b_op2
  );

  modport slave (
    input  enq0_valid, enq1_valid, enq0_opr, enq1_opr, enq0_is_br, enq1_is_br,
           enq0_rd, enq0_rs1, enq0_rs2, enq1_rd, enq1_rs1, enq1_rs2,
           enq0_op1, enq0_op2, enq1_op1, enq1_op2, issue_stall,
    output enq_ready, a_valid, a_opr, a_is_br, a_rd, a_op1, a_op2,
           b_valid, b_opr, b_rd, b_op1, b_op2
  );
endinterface

// File: rtl/alu_issue_queue.sv
// alu_issue_queue
//   Dual-issue in-order queue between register-read and the two ALUs.
//   Slot A feeds the branch-capable ALU, slot B the arithmetic-only ALU.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     flush  discard all queued and staged ops (branch redirect)
//     bus    alu_issue_queue_if.slave: enqueue lanes, enq_ready,
//            issue_stall and registered slot A/B outputs
//   Configuration macro:
//     ALU_ISSUE_RAW_CHECK_EN  when defined, a head+1 op that reads the head's
//                             destination register is kept off slot B.
//                             When undefined, rs1/rs2 are not used.
module alu_issue_queue #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  alu_issue_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   READY_MAX = (PW+1)'(DEPTH - 2);
  localparam logic [PW:0]   CNT_ZERO  = (PW+1)'(1'b0);
  localparam logic [PW:0]   CNT_TWO   = (PW+1)'(2'd2);
  localparam logic [PW-1:0] PTR_ZERO  = PW'(1'b0);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);

  // Payload storage
  logic [3:0]  opr_mem [DEPTH];
  logic        br_mem  [DEPTH];
  logic [4:0]  rd_mem  [DEPTH];
  logic [63:0] op1_mem [DEPTH];
  logic [63:0] op2_mem [DEPTH];
`ifdef ALU_ISSUE_RAW_CHECK_EN
  logic [4:0]  rs1_mem [DEPTH];
  logic [4:0]  rs2_mem [DEPTH];
`else
  logic        unused_rs_s;
  assign unused_rs_s = ^{bus.enq0_rs1, bus.enq0_rs2, bus.enq1_rs1, bus.enq1_rs2};
`endif

  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [PW:0]   count_r;

  logic          enq_ready_s;
  logic [1:0]    enq_n_s;
  logic [1:0]    deq_n_s;
  logic [PW-1:0] next_ptr_s;
  logic [PW-1:0] tail_next_s;
  logic          has_head_s;
  logic          has_next_s;
  logic          raw_s;
  logic          pair_s;

  assign bus.enq_ready = enq_ready_s;

  // Enqueue acceptance and issue pairing decision for this cycle
  always_comb begin
    enq_ready_s = (count_r <= READY_MAX);
    next_ptr_s  = head_r + PTR_ONE;
    tail_next_s = tail_r + PTR_ONE;
    has_head_s  = (count_r != CNT_ZERO);
    has_next_s  = (count_r >= CNT_TWO);
    raw_s       = 1'b0;
    if (enq_ready_s && bus.enq0_valid) begin
      enq_n_s = bus.enq1_valid ? 2'd2 : 2'd1;
    end else begin
      enq_n_s = 2'd0;
    end
`ifdef ALU_ISSUE_RAW_CHECK_EN
    raw_s = (rd_mem[head_r] != 5'd0) &&
            ((rs1_mem[next_ptr_s] == rd_mem[head_r]) ||
             (rs2_mem[next_ptr_s] == rd_mem[head_r]));
`endif
    // Stored entries beyond count are stale; has_next_s masks them.
    pair_s = has_next_s && !br_mem[head_r] && !br_mem[next_ptr_s] && !raw_s;
    if (flush || bus.issue_stall) begin
      deq_n_s = 2'd0;
    end else if (!has_head_s) begin
      deq_n_s = 2'd0;
    end else if (pair_s) begin
      deq_n_s = 2'd2;
    end else begin
      deq_n_s = 2'd1;
    end
  end

  // Payload writes; entries above count are never read, so no reset is needed
  always_ff @(posedge clk) begin
    if (!flush && (enq_n_s != 2'd0)) begin
      opr_mem[tail_r] <= bus.enq0_opr;
      br_mem[tail_r]  <= bus.enq0_is_br;
      rd_mem[tail_r]  <= bus.enq0_rd;
      op1_mem[tail_r] <= bus.enq0_op1;
      op2_mem[tail_r] <= bus.enq0_op2;
`ifdef ALU_ISSUE_RAW_CHECK_EN
      rs1_mem[tail_r] <= bus.enq0_rs1;
      rs2_mem[tail_r] <= bus.enq0_rs2;
`endif
      if (enq_n_s == 2'd2) begin
        opr_mem[tail_next_s] <= bus.enq1_opr;
        br_mem[tail_next_s]  <= bus.enq1_is_br;
        rd_mem[tail_next_s]  <= bus.enq1_rd;
        op1_mem[tail_next_s] <= bus.enq1_op1;
        op2_mem[tail_next_s] <= bus.enq1_op2;
`ifdef ALU_ISSUE_RAW_CHECK_EN
        rs1_mem[tail_next_s] <= bus.enq1_rs1;
        rs2_mem[tail_next_s] <= bus.enq1_rs2;
`endif
      end
    end
  end

  // Pointers, count and registered issue slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r      <= PTR_ZERO;
      tail_r      <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      bus.a_valid <= 1'b0;
      bus.a_opr   <= 4'd0;
      bus.a_is_br <= 1'b0;
      bus.a_rd    <= 5'd0;
      bus.a_op1   <= 64'd0;
      bus.a_op2   <= 64'd0;
      bus.b_valid <= 1'b0;
      bus.b_opr   <= 4'd0;
      bus.b_rd    <= 5'd0;
      bus.b_op1   <= 64'd0;
      bus.b_op2   <= 64'd0;
    end else if (flush) begin
      // Redirect wins over enqueue, issue and stall.
      head_r      <= PTR_ZERO;
      tail_r      <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      bus.a_valid <= 1'b0;
      bus.b_valid <= 1'b0;
    end else begin
      tail_r  <= tail_r + PW'(enq_n_s);
      head_r  <= head_r + PW'(deq_n_s);
      count_r <= count_r + (PW+1)'(enq_n_s) - (PW+1)'(deq_n_s);
      if (!bus.issue_stall) begin
        bus.a_valid <= has_head_s;
        bus.a_opr   <= has_head_s ? opr_mem[head_r] : 4'd0;
        bus.a_is_br <= has_head_s ? br_mem[head_r]  : 1'b0;
        bus.a_rd    <= has_head_s ? rd_mem[head_r]  : 5'd0;
        bus.a_op1   <= has_head_s ? op1_mem[head_r] : 64'd0;
        bus.a_op2   <= has_head_s ? op2_mem[head_r] : 64'd0;
        bus.b_valid <= pair_s;
        bus.b_opr   <= pair_s ? opr_mem[next_ptr_s] : 4'd0;
        bus.b_rd    <= pair_s ? rd_mem[next_ptr_s]  : 5'd0;
        bus.b_op1   <= pair_s ? op1_mem[next_ptr_s] : 64'd0;
        bus.b_op2   <= pair_s ? op2_mem[next_ptr_s] : 64'd0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue
//   Directed bench for alu_issue_queue (DEPTH=8). Operands are derived from
//   rd (op1 = 0xA000+rd, op2 = 0xB000+rd) so slot data can be predicted.
module tb_alu_issue_queue;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   errors = 0;
  int   checks = 0;

`ifdef ALU_ISSUE_RAW_CHECK_EN
  localparam bit RAW_ON = 1'b1;
`else
  localparam bit RAW_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_issue_queue_if bus ();

  alu_issue_queue #(.DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int lane, input logic [3:0] opr, input logic br,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    if (lane == 0) begin
      bus.enq0_valid = 1'b1; bus.enq0_opr = opr; bus.enq0_is_br = br;
      bus.enq0_rd = rd; bus.enq0_rs1 = rs1; bus.enq0_rs2 = rs2;
      bus.enq0_op1 = 64'hA000 + 64'(rd); bus.enq0_op2 = 64'hB000 + 64'(rd);
    end else begin
      bus.enq1_valid = 1'b1; bus.enq1_opr = opr; bus.enq1_is_br = br;
      bus.enq1_rd = rd; bus.enq1_rs1 = rs1; bus.enq1_rs2 = rs2;
      bus.enq1_op1 = 64'hA000 + 64'(rd); bus.enq1_op2 = 64'hB000 + 64'(rd);
    end
  endtask

  task automatic idle();
    bus.enq0_valid = 1'b0; bus.enq1_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; bus.issue_stall = 1'b0;
    idle();
    set_lane(0, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    set_lane(1, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle();

    // Reset state
    #2 rst_n = 1'b0;
    #2;
    chk("rst_a_valid", bus.a_valid, 1'b0);
    chk("rst_b_valid", bus.b_valid, 1'b0);
    chk("rst_a_rd", bus.a_rd, 5'd0);
    chk("rst_a_op1", bus.a_op1, 64'd0);
    chk("rst_enq_ready", bus.enq_ready, 1'b1);
    #8 rst_n = 1'b1;
    tick();

    // Independent pair issues together two edges after enqueue
    set_lane(0, 4'b0000, 1'b0, 5'd5, 5'd1, 5'd2);
    set_lane(1, 4'b0001, 1'b0, 5'd6, 5'd7, 5'd8);
    tick(); idle();
    chk("t1_count_after_enq", dut.count_r, 4'd2);
    chk("t1_not_yet_valid", bus.a_valid, 1'b0);
    tick();
    chk("t1_a_valid", bus.a_valid, 1'b1);
    chk("t1_a_rd", bus.a_rd, 5'd5);
    chk("t1_a_op1", bus.a_op1, 64'hA005);
    chk("t1_b_valid", bus.b_valid, 1'b1);
    chk("t1_b_rd", bus.b_rd, 5'd6);
    chk("t1_b_opr", bus.b_opr, 4'b0001);
    chk("t1_b_op2", bus.b_op2, 64'hB006);
    chk("t1_count_zero", dut.count_r, 4'd0);
    tick();
    chk("t1_drained", bus.a_valid, 1'b0);

    // RAW pair: second op reads rd=3 of the first
    set_lane(0, 4'd2, 1'b0, 5'd3, 5'd1, 5'd1);
    set_lane(1, 4'd3, 1'b0, 5'd4, 5'd9, 5'd3);
    tick(); idle(); tick();
    chk("t2_a_rd", bus.a_rd, 5'd3);
    chk("t2_b_valid", bus.b_valid, RAW_ON ? 1'b0 : 1'b1);
    tick();
    chk("t2_second_a_valid", bus.a_valid, RAW_ON ? 1'b1 : 1'b0);
    chk("t2_second_a_rd", bus.a_rd, RAW_ON ? 5'd4 : 5'd0);
    tick();
    chk("t2_drained", bus.a_valid, 1'b0);

    // Branch then add: branch alone, add next cycle on A
    set_lane(0, 4'd4, 1'b1, 5'd1, 5'd0, 5'd0);
    set_lane(1, 4'd5, 1'b0, 5'd2, 5'd0, 5'd0);
    tick(); idle(); tick();
    chk("t3_br_a_is_br", bus.a_is_br, 1'b1);
    chk("t3_br_a_rd", bus.a_rd, 5'd1);
    chk("t3_br_b_valid", bus.b_valid, 1'b0);
    tick();
    chk("t3_add_a_rd", bus.a_rd, 5'd2);
    chk("t3_add_a_is_br", bus.a_is_br, 1'b0);
    chk("t3_add_b_valid", bus.b_valid, 1'b0);

    // Add then branch: branch may not take slot B
    set_lane(0, 4'd5, 1'b0, 5'd9, 5'd0, 5'd0);
    set_lane(1, 4'd4, 1'b1, 5'd10, 5'd0, 5'd0);
    tick(); idle(); tick();
    chk("t3b_a_rd", bus.a_rd, 5'd9);
    chk("t3b_b_valid", bus.b_valid, 1'b0);
    tick();
    chk("t3b_br_a_rd", bus.a_rd, 5'd10);
    chk("t3b_br_a_is_br", bus.a_is_br, 1'b1);

    // Fill under stall to DEPTH-1; outputs stay frozen on the branch
    bus.issue_stall = 1'b1;
    set_lane(0, 4'd1, 1'b0, 5'd11, 5'd0, 5'd0); set_lane(1, 4'd1, 1'b0, 5'd12, 5'd0, 5'd0); tick();
    set_lane(0, 4'd1, 1'b0, 5'd13, 5'd0, 5'd0); set_lane(1, 4'd1, 1'b0, 5'd14, 5'd0, 5'd0); tick();
    set_lane(0, 4'd1, 1'b0, 5'd15, 5'd0, 5'd0); set_lane(1, 4'd1, 1'b0, 5'd16, 5'd0, 5'd0); tick();
    chk("t4_ready_at_6", bus.enq_ready, 1'b1);
    idle(); set_lane(0, 4'd1, 1'b0, 5'd17, 5'd0, 5'd0); tick();
    chk("t4_ready_at_7", bus.enq_ready, 1'b0);
    chk("t4_count_7", dut.count_r, 4'd7);
    chk("t4_frozen_a_valid", bus.a_valid, 1'b1);
    chk("t4_frozen_a_rd", bus.a_rd, 5'd10);
    chk("t4_frozen_a_is_br", bus.a_is_br, 1'b1);
    chk("t4_frozen_b_valid", bus.b_valid, 1'b0);
    set_lane(0, 4'd1, 1'b0, 5'd30, 5'd0, 5'd0); set_lane(1, 4'd1, 1'b0, 5'd31, 5'd0, 5'd0); tick();
    chk("t4_dropped_count", dut.count_r, 4'd7);
    idle(); bus.issue_stall = 1'b0; tick();
    chk("t4_d1_a_rd", bus.a_rd, 5'd11);
    chk("t4_d1_b_rd", bus.b_rd, 5'd12);
    chk("t4_d1_ready", bus.enq_ready, 1'b1);
    tick();
    chk("t4_d2_a_rd", bus.a_rd, 5'd13);
    chk("t4_d2_b_rd", bus.b_rd, 5'd14);
    tick();
    chk("t4_d3_a_rd", bus.a_rd, 5'd15);
    chk("t4_d3_b_rd", bus.b_rd, 5'd16);
    tick();
    chk("t4_d4_a_rd", bus.a_rd, 5'd17);
    chk("t4_d4_b_valid", bus.b_valid, 1'b0);
    tick();
    chk("t4_empty", bus.a_valid, 1'b0);
    chk("t4_count_0", dut.count_r, 4'd0);

    // Flush with enqueue and issue pending at count=5
    set_lane(0, 4'd1, 1'b0, 5'd20, 5'd0, 5'd0); set_lane(1, 4'd1, 1'b0, 5'd21, 5'd0, 5'd0); tick();
    set_lane(0, 4'd1, 1'b0, 5'd22, 5'd0, 5'd0); set_lane(1, 4'd1, 1'b0, 5'd23, 5'd0, 5'd0); tick();
    chk("t5_a_rd", bus.a_rd, 5'd20);
    bus.issue_stall = 1'b1;
    set_lane(0, 4'd1, 1'b0, 5'd24, 5'd0, 5'd0); set_lane(1, 4'd1, 1'b0, 5'd25, 5'd0, 5'd0); tick();
    idle(); set_lane(0, 4'd1, 1'b0, 5'd26, 5'd0, 5'd0); tick();
    chk("t5_count_5", dut.count_r, 4'd5);
    chk("t5_held_a_valid", bus.a_valid, 1'b1);
    flush = 1'b1; bus.issue_stall = 1'b0;
    set_lane(0, 4'd1, 1'b0, 5'd27, 5'd0, 5'd0); set_lane(1, 4'd1, 1'b0, 5'd28, 5'd0, 5'd0); tick();
    chk("t5_flush_count", dut.count_r, 4'd0);
    chk("t5_flush_a_valid", bus.a_valid, 1'b0);
    chk("t5_flush_b_valid", bus.b_valid, 1'b0);
    flush = 1'b0; idle(); tick();
    chk("t5_discarded_a_valid", bus.a_valid, 1'b0);
    chk("t5_discarded_count", dut.count_r, 4'd0);

    // Asynchronous reset with a full queue and valid outputs
    set_lane(0, 4'd1, 1'b0, 5'd20, 5'd0, 5'd0); set_lane(1, 4'd1, 1'b0, 5'd21, 5'd0, 5'd0); tick();
    set_lane(0, 4'd1, 1'b0, 5'd22, 5'd0, 5'd0); set_lane(1, 4'd1, 1'b0, 5'd23, 5'd0, 5'd0); tick();
    bus.issue_stall = 1'b1;
    set_lane(0, 4'd1, 1'b0, 5'd24, 5'd0, 5'd0); set_lane(1, 4'd1, 1'b0, 5'd25, 5'd0, 5'd0); tick();
    set_lane(0, 4'd1, 1'b0, 5'd26, 5'd0, 5'd0); set_lane(1, 4'd1, 1'b0, 5'd27, 5'd0, 5'd0); tick();
    idle(); set_lane(0, 4'd1, 1'b0, 5'd28, 5'd0, 5'd0); tick();
    idle();
    chk("t6_full_ready", bus.enq_ready, 1'b0);
    chk("t6_pre_a_rd", bus.a_rd, 5'd20);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_a_valid", bus.a_valid, 1'b0);
    chk("t6_async_a_rd", bus.a_rd, 5'd0);
    chk("t6_async_a_op1", bus.a_op1, 64'd0);
    chk("t6_async_b_valid", bus.b_valid, 1'b0);
    chk("t6_async_b_rd", bus.b_rd, 5'd0);
    chk("t6_async_ready", bus.enq_ready, 1'b1);
    #2 rst_n = 1'b1; bus.issue_stall = 1'b0;
    tick();
    chk("t6_post_a_valid", bus.a_valid, 1'b0);
    chk("t6_post_ready", bus.enq_ready, 1'b1);
    chk("t6_post_count", dut.count_r, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Dual-issue in-order queue feeding the two execution ALUs of the 2-way superscalar core. Decoded ops with resolved operand values enter on two enqueue lanes. Up to two ops leave per cycle on registered issue ports. Slot A drives the branch-capable ALU; slot B drives the arithmetic-only ALU. Sits between decode/register-read and execute, and absorbs decode bursts and execute stalls.

## Interface

Parameters:
- DEPTH, 8 — queue entries; power of 2, ≥4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all queued and staged ops (branch redirect).
- enq0_valid, enq1_valid  in  1 each  lane valids. Lane 0 is older. enq1 is ignored unless enq0_valid.
- enq0_opr, enq1_opr  in  4 each  ALU opcode.
- enq0_is_br, enq1_is_br  in  1 each  op is a branch; may issue on slot A only.
- enq0_rd/rs1/rs2, enq1_rd/rs1/rs2  in  5 each  register indices.
- enq0_op1/op2, enq1_op1/op2  in  64 each  operand values.
- enq_ready  out  1  high when at least 2 entries are free.
- issue_stall  in  1  execute cannot accept; hold issue outputs.
- a_valid  out  1  slot A valid.
- a_opr  out  4  slot A opcode.
- a_is_br  out  1  slot A branch flag.
- a_rd  out  5  slot A destination register.
- a_op1, a_op2  out  64 each  slot A operands.
- b_valid, b_opr, b_rd, b_op1, b_op2  out  1/4/5/64/64  slot B, same meanings as slot A.

## Operation

- Storage: circular buffer of DEPTH entries with head pointer, tail pointer and count (log2(DEPTH)+1 bits). Pointers wrap modulo DEPTH.
- Enqueue: requires enq_ready. enq_ready is computed combinationally from the registered count: count ≤ DEPTH−2.
  - enq0 only: writes 1 entry.
  - enq0 and enq1: write 2 entries, enq0 at tail and enq1 at tail+1.
  - Valids asserted while enq_ready is low are dropped. The producer must not do this.
- Issue selection, evaluated when issue_stall=0 and flush=0:
  - Head, if present, goes to slot A.
  - Head+1 goes to slot B only if all hold: it exists; it is not a branch; head is not a branch; no RAW hazard.
  - RAW hazard: head.rd ≠ 0 and (head+1.rs1 = head.rd or head+1.rs2 = head.rd).
  - Otherwise only slot A issues. Order is strictly in-order; slot A always carries the older op.
- Output registers:
  - Selected ops load a_*/b_* on the edge; unselected slot valid loads 0.
  - The queue dequeues 0, 1 or 2 entries accordingly.
  - An empty queue loads a_valid = b_valid = 0.
- Count update: count_next = count + enq_n − deq_n. Simultaneous enqueue and dequeue are legal in the same cycle.
- issue_stall=1: output registers, head and dequeue are all frozen. Enqueue still proceeds.
- flush=1: on the next edge, count, head and tail go to 0 and a_valid = b_valid = 0. Flush overrides enqueue, issue and stall in that cycle.

## Timing

- Reset (async assert, sync to clk on deassert):
  - count, head and tail are 0.
  - All a_*/b_* outputs are 0.
  - enq_ready is 1.
- Latency: an op enqueued at edge N enters the queue at N. If it is head at that point and not stalled, it appears on a_* after edge N+1. Minimum 2 edges from enq to issue.
- Throughput: 2 ops/cycle sustained when the pair is hazard-free and contains no branch.
- Full: count = DEPTH−1 or DEPTH drives enq_ready=0. Count never exceeds DEPTH.
- Reset mid-operation: contents are lost immediately and outputs go to 0 asynchronously.

## Configuration

- ALU_ISSUE_RAW_CHECK_EN defined: the RAW hazard check above is active.
- Without it: pairing ignores register dependences, so only the branch rules limit dual issue. Use only when the compiler guarantees independent pairs. The rs1/rs2 inputs are then unused.

## Test plan

- Reset, then enq0 (opr=0000, rd=5) and enq1 (opr=0001, rd=6, rs1=7) in one cycle → after 2 edges a_valid=1 with a_rd=5 and b_valid=1 with b_rd=6; count returns to 0.
- Pair where enq1.rs2 = enq0.rd = 3 → first issue: a only, b_valid=0. Next cycle: the second op issues on slot A. With macro undefined, both issue together.
- Head is_br=1 followed by an add → branch issues alone on A, the add issues next cycle on A. An add followed by a branch → add on A, branch next cycle on A.
- Enqueue pairs with issue_stall=1 until count=DEPTH−1 → enq_ready drops, outputs stay frozen with their values unchanged. Release stall → ops drain in order and enq_ready returns to 1.
- flush asserted together with enqueue and issue while count=5 → next edge count=0, a_valid=b_valid=0, and the enqueued ops are discarded.
- Assert rst_n=0 mid-stream with the queue full → outputs go to 0 without waiting for a clk edge, and enq_ready=1 after release.
